// File: rtl/map_tile_controller.sv
// Live 20x20 tile map owner: streams each level in from the level ROM, then arbitrates
// single-tile edits (kill path, enemy mover) and ladder-driven level advance.
module map_tile_controller #(
  parameter int NUM_LEVELS = 4,
  localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 next_level_req,
  input  logic                 kill_req,
  input  logic [4:0]           kill_row,
  input  logic [4:0]           kill_col,
  input  logic                 enemy_wr_req,
  input  logic [8:0]           enemy_wr_addr,
  input  logic [4:0]           enemy_wr_data,
  output logic [LVL_W+8:0]     rom_addr,
  input  logic [4:0]           rom_data,
  output logic [0:399][4:0]    mapData,
  output logic [LVL_W-1:0]     level,
  output logic                 map_valid,
  output logic                 load_busy,
  output logic                 kill_ack,
  output logic                 kill_hit,
  output logic                 enemy_wr_ack,
  output logic [8:0]           enemies_left,
  output logic                 game_won,
  output logic [1:0]           state_dbg
);

  // Handshake: kill_req / enemy_wr_req are level-held; each is accepted in RUN, acked with a
  // one-cycle registered pulse next cycle, and ignored during its own ack cycle.
  typedef enum logic [1:0] {S_LOAD = 2'd0, S_RUN = 2'd1, S_WON = 2'd2} state_t;

  localparam logic [8:0] LAST_IDX    = 9'd399;
  localparam logic [8:0] MAX_ENEMIES = 9'd400;
  localparam logic [LVL_W-1:0] LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);

  function automatic logic is_enemy(input logic [4:0] code);
    case (code)
      5'd3, 5'd4, 5'd10, 5'd11, 5'd12, 5'd13: is_enemy = 1'b1;
      default:                                is_enemy = 1'b0;
    endcase
  endfunction

  function automatic logic [8:0] cnt_inc(input logic [8:0] c);
    return (c >= MAX_ENEMIES) ? MAX_ENEMIES : c + 9'd1;
  endfunction

  function automatic logic [8:0] cnt_dec(input logic [8:0] c);
    return (c == 9'd0) ? 9'd0 : c - 9'd1;
  endfunction

  state_t             state_q, state_d;
  logic [8:0]         idx_q, idx_d;
  logic               wr_valid_q, wr_valid_d;
  logic [8:0]         wr_idx_q, wr_idx_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [0:399][4:0]  map_q, map_d;
  logic [8:0]         enemies_q, enemies_d;
  logic               kill_ack_q, kill_ack_d;
  logic               kill_hit_q, kill_hit_d;
  logic               enemy_ack_q, enemy_ack_d;
  logic               won_q, won_d;

  logic [8:0]         kill_idx;
  logic               kill_in_range;
  logic [4:0]         kill_old;
  logic [4:0]         enemy_old;
  logic               new_e, old_e;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_valid_d  = wr_valid_q;
    wr_idx_d    = wr_idx_q;
    level_d     = level_q;
    map_d       = map_q;
    enemies_d   = enemies_q;
    kill_ack_d  = 1'b0;
    kill_hit_d  = 1'b0;
    enemy_ack_d = 1'b0;
    won_d       = won_q;

    kill_idx      = ({4'd0, kill_row} * 9'd20) + {4'd0, kill_col};
    kill_in_range = (kill_row < 5'd20) && (kill_col < 5'd20);
    kill_old      = kill_in_range ? map_q[kill_idx] : 5'd0;
    enemy_old     = (enemy_wr_addr <= LAST_IDX) ? map_q[enemy_wr_addr] : 5'd0;
    new_e         = is_enemy(enemy_wr_data);
    old_e         = is_enemy(enemy_old);

    case (state_q)
      S_LOAD: begin
        // Address phase runs one cycle ahead of the write phase to absorb ROM latency.
        idx_d      = (idx_q == LAST_IDX) ? idx_q : idx_q + 9'd1;
        wr_valid_d = 1'b1;
        wr_idx_d   = idx_q;
        if (wr_valid_q) begin
          map_d[wr_idx_q] = rom_data;
          if (is_enemy(rom_data)) enemies_d = cnt_inc(enemies_q);
          if (wr_idx_q == LAST_IDX) begin
            state_d    = S_RUN;
            wr_valid_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (next_level_req) begin
          if (level_q == LAST_LEVEL) begin
            state_d = S_WON;
            won_d   = 1'b1;
          end else begin
            state_d    = S_LOAD;
            level_d    = level_q + LVL_W'(1);
            idx_d      = 9'd0;
            wr_valid_d = 1'b0;
            enemies_d  = 9'd0;
          end
        end else if (kill_req && !kill_ack_q) begin
          kill_ack_d = 1'b1;
          if (kill_in_range && is_enemy(kill_old)) begin
            map_d[kill_idx] = 5'd0;
            kill_hit_d      = 1'b1;
            enemies_d       = cnt_dec(enemies_q);
          end
        end else if (enemy_wr_req && !enemy_ack_q) begin
          enemy_ack_d = 1'b1;
          if (enemy_wr_addr <= LAST_IDX) begin
            map_d[enemy_wr_addr] = enemy_wr_data;
            if (new_e && !old_e)      enemies_d = cnt_inc(enemies_q);
            else if (!new_e && old_e) enemies_d = cnt_dec(enemies_q);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      idx_q       <= 9'd0;
      wr_valid_q  <= 1'b0;
      wr_idx_q    <= 9'd0;
      level_q     <= '0;
      map_q       <= '0;
      enemies_q   <= 9'd0;
      kill_ack_q  <= 1'b0;
      kill_hit_q  <= 1'b0;
      enemy_ack_q <= 1'b0;
      won_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_valid_q  <= wr_valid_d;
      wr_idx_q    <= wr_idx_d;
      level_q     <= level_d;
      map_q       <= map_d;
      enemies_q   <= enemies_d;
      kill_ack_q  <= kill_ack_d;
      kill_hit_q  <= kill_hit_d;
      enemy_ack_q <= enemy_ack_d;
      won_q       <= won_d;
    end
  end

  // idx parks at 399 once a load finishes, so rom_addr holds {level,399} outside LOAD.
  assign rom_addr     = {level_q, idx_q};
  assign mapData      = map_q;
  assign level        = level_q;
  assign map_valid    = (state_q != S_LOAD);
  assign load_busy    = (state_q == S_LOAD);
  assign kill_ack     = kill_ack_q;
  assign kill_hit     = kill_hit_q;
  assign enemy_wr_ack = enemy_ack_q;
  assign enemies_left = enemies_q;
  assign game_won     = won_q;
  assign state_dbg    = state_q;

endmodule
